// File: rtl/alu4_seq_pkg.sv
// Shared constants and types for the nibble-serial ALU: op codes, FSM states,
// nibble width and the initial-carry rule.
package alu4_seq_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_PASA = 3'd5,
        OP_NOTA = 3'd6,
        OP_INC  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // SUB is a + ~b + ~cin, so its borrow-in enters the chain inverted
    function automatic logic init_carry(input op_e op, input logic cin);
        case (op)
            OP_ADD:  return cin;
            OP_SUB:  return ~cin;
            OP_INC:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu4_nib.sv
// Combinational 4-bit slice: one nibble of the selected operation plus carry.
module alu4_nib
    import alu4_seq_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  op_e              op,
    input  logic             ci,
    output logic [NIB_W-1:0] f,
    output logic             co
);

    logic [NIB_W:0] sum;

    always_comb begin
        sum = '0;
        f   = '0;
        co  = 1'b0;
        case (op)
            OP_ADD:  sum = {1'b0, a} + {1'b0, b}  + {{NIB_W{1'b0}}, ci};
            OP_SUB:  sum = {1'b0, a} + {1'b0, ~b} + {{NIB_W{1'b0}}, ci};
            OP_INC:  sum = {1'b0, a} + {{NIB_W{1'b0}}, ci};
            OP_AND:  sum = {1'b0, a & b};
            OP_OR:   sum = {1'b0, a | b};
            OP_XOR:  sum = {1'b0, a ^ b};
            OP_PASA: sum = {1'b0, a};
            OP_NOTA: sum = {1'b0, ~a};
            default: sum = '0;
        endcase
        f  = sum[NIB_W-1:0];
        // logic ops never carry, so cout falls out as 0 for them
        co = (op == OP_ADD || op == OP_SUB || op == OP_INC) ? sum[NIB_W] : 1'b0;
    end

endmodule

// File: rtl/alu4_seq.sv
// Nibble-serial ALU: captures operands on accept, computes one nibble per cycle
// LSB first with a registered carry, then presents the result until consumed.
module alu4_seq
    import alu4_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NIB_W*NIBBLES-1:0] op_a,
    input  logic [NIB_W*NIBBLES-1:0] op_b,
    input  logic [2:0]               op,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NIB_W*NIBBLES-1:0] res,
    output logic                     cout,
    output logic                     zero,
    output logic                     busy
);

    localparam int W  = NIB_W * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_e          state;
    logic [IW-1:0]   idx;
    logic            carry;
    logic            fin;
    logic [W-1:0]    a_q, b_q;
    op_e             op_q;
    logic [NIB_W-1:0] nib_f;
    logic            nib_co;

    alu4_nib u_nib (
        .a  (a_q[idx*NIB_W +: NIB_W]),
        .b  (b_q[idx*NIB_W +: NIB_W]),
        .op (op_q),
        .ci (carry),
        .f  (nib_f),
        .co (nib_co)
    );

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            carry <= 1'b0;
            fin   <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= OP_ADD;
            res   <= '0;
            cout  <= 1'b0;
            zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q   <= op_a;
                        b_q   <= op_b;
                        op_q  <= op_e'(op);
                        carry <= init_carry(op_e'(op), cin);
                        idx   <= '0;
                        fin   <= 1'b0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!fin) begin
                        res[idx*NIB_W +: NIB_W] <= nib_f;
                        carry <= nib_co;
                        if (idx == IW'(NIBBLES - 1)) fin <= 1'b1;
                        else                         idx <= idx + 1'b1;
                    end else begin
                        // extra cycle lets zero see the fully assembled result
                        zero  <= (res == '0);
                        cout  <= carry;
                        fin   <= 1'b0;
                        idx   <= '0;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu4_seq.md
ALU4_SEQ -- requirements
Module: alu4_seq

Interface
REQ-001 Parameter NIBBLES, default 4, SHALL set the operand width to 4*NIBBLES bits (W).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  request present; in_ready  out  1  block can accept.
REQ-005 op_a, op_b  in  W  operands, sampled on accept.
REQ-006 op  in  3  operation code, sampled on accept; cin  in  1  carry in, sampled on accept.
REQ-007 out_valid  out  1  result present; out_ready  in  1  consumer accepts.
REQ-008 res  out  W  result; cout  out  1  carry/borrow out; zero  out  1  res == 0.
REQ-009 busy  out  1  high whenever state is not IDLE.

Function
REQ-010 Accept SHALL occur when in_valid && in_ready; in_ready SHALL be high only in IDLE.
REQ-011 States SHALL be IDLE, RUN, DONE; IDLE->RUN on accept, RUN->DONE after the last nibble, DONE->IDLE on out_valid && out_ready.
REQ-012 In RUN exactly one 4-bit nibble SHALL be computed per cycle, LSB nibble first, index counter 0..NIBBLES-1.
REQ-013 Carry SHALL be registered between nibbles; nibble 0 uses the initial carry from REQ-015.
REQ-014 op codes: 0 ADD a+b+cin; 1 SUB a-b-cin as a+~b+~cin; 2 AND; 3 OR; 4 XOR; 5 PASSA; 6 NOTA; 7 INC a+1 (cin ignored).
REQ-015 Initial carry: ADD cin, SUB ~cin, INC 1, logic ops 0.
REQ-016 cout SHALL be carry out of the top nibble for ops 0,1,7 and 0 for ops 2-6; for SUB cout=1 means no borrow.
REQ-017 Latency SHALL be exactly NIBBLES+1 cycles from accept edge to out_valid high (NIBBLES=4: 5).
REQ-018 res, cout, zero SHALL hold stable while out_valid && !out_ready (backpressure, no limit on stall length).
REQ-019 out_valid SHALL be high only in DONE; res/cout/zero are don't-care otherwise but SHALL NOT change in DONE.
REQ-020 Operands SHALL be captured in registers at accept; input changes during RUN/DONE SHALL NOT affect the result.
REQ-021 No new request SHALL be accepted in the same cycle a result is consumed; next accept earliest one cycle after DONE->IDLE.
REQ-022 Arithmetic SHALL wrap modulo 2^W (0xFFFF+1 = 0x0000, cout=1).
REQ-023 zero SHALL be computed from the full W-bit result, registered with res.

Reset
REQ-024 On rst: state IDLE, nibble counter 0, carry 0, res 0, cout 0, zero 0, out_valid 0, busy 0, in_ready 1 in the following cycle.
REQ-025 rst asserted during RUN or DONE SHALL abort the operation, discard the result, and win over any simultaneous handshake.

Structure
REQ-026 Op-code constants, state encoding and nibble width SHALL live in a shared package alu4_seq_pkg.
REQ-027 The 4-bit combinational nibble datapath (a, b, op, carry in -> f, carry out) SHALL be a separate sub-module alu4_nib; the sequencer owns FSM, counter, carry and result registers.

Verification
REQ-028 ADD a=0x1234, b=0x0FFF, cin=0 -> res=0x2233, cout=0, zero=0, out_valid exactly 5 cycles after accept.
REQ-029 SUB a=0x0005, b=0x0005, cin=0 -> res=0x0000, cout=1, zero=1; SUB a=0x0000, b=0x0001 -> res=0xFFFF, cout=0.
REQ-030 INC a=0xFFFF -> res=0x0000, cout=1, zero=1; ADD a=0x00F0, b=0x0010 -> nibble carry chain res=0x0100.
REQ-031 XOR a=0xAAAA, b=0xFFFF with out_ready low for 10 cycles -> res=0x5555 held stable, in_ready low throughout, released on out_ready.
REQ-032 rst pulsed on cycle 2 of RUN -> out_valid never rises, in_ready=1 next cycle, following ADD 1+1 -> res=0x0002.
REQ-033 Back-to-back: in_valid held high with two requests -> second accepted one cycle after first consumed, both results correct and ordered.
